result_capture_fifo: RTL and testbench

//  Downstream stage of the processor top level. Captures each executed

---
 rtl/result_capture_fifo.sv | 150 +++++++++++++++
 tb/tb_result_capture_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/result_capture_fifo.sv
// Result capture buffer: stores {flags,result} per executed instruction and
// drains it first-word-fall-through over valid/ready, then reports drained.
module result_capture_fifo #(
    parameter int DATA_W = 8,
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [FLAG_W-1:0]          in_flags,
    input  logic                       in_done,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [FLAG_W+DATA_W-1:0]   out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           total_results,
    output logic                       drained
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = FLAG_W + DATA_W;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_ZERO   = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(1'b0);
    localparam logic [CNT_W-1:0] TOTAL_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TOTAL_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] TOTAL_ZERO = CNT_W'(1'b0);
    localparam logic [ENTRY_W-1:0] ENTRY_ZERO = ENTRY_W'(1'b0);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_FINISHED = 2'd2
    } state_t;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     count_r;
    logic [PTR_W:0]     count_next_s;
    state_t             state_r;
    state_t             state_next_s;
    logic               overflow_r;
    logic [CNT_W-1:0]   total_r;
    logic               full_s;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;

    // Handshake qualification; a full buffer refuses pushes even when popping
    always_comb begin
        full_s      = (count_r == FULL_COUNT);
        in_ready_s  = (state_r == ST_RUN) && !full_s;
        out_valid_s = (state_r != ST_FINISHED) && (count_r != CNT_ZERO);
        push_s      = in_valid && in_ready_s;
        pop_s       = out_valid_s && out_ready;
        drop_s      = in_valid && (state_r == ST_RUN) && full_s;
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // End-of-execution sequencing; FLUSH exits on the edge that empties the buffer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (in_done) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (count_next_s == CNT_ZERO) begin
                    state_next_s = ST_FINISHED;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_FINISHED: state_next_s = ST_FINISHED;
            default:     state_next_s = ST_RUN;
        endcase
    end

    // Control state, pointers, occupancy and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_RUN;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
            total_r    <= TOTAL_ZERO;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (push_s && (total_r != TOTAL_MAX)) begin
                total_r <= total_r + TOTAL_ONE;
            end
        end
    end

    // Entry storage, cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {in_flags, in_result};
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_s;
    assign out_data      = mem_r[rd_ptr_r];
    assign count         = count_r;
    assign overflow      = overflow_r;
    assign total_results = total_r;
    assign drained       = (state_r == ST_FINISHED);

endmodule

// File: tb/tb_result_capture_fifo.sv
// Randomized scoreboard bench for result_capture_fifo, with a second
// instance using a 2-bit result counter to observe saturation.
module tb_result_capture_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_result = 8'h00;
    logic [3:0]  in_flags = 4'h0;
    logic        in_done = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] total_results;
    logic        drained;

    logic        in_ready2;
    logic        out_valid2;
    logic [11:0] out_data2;
    logic [3:0]  count2;
    logic        overflow2;
    logic [1:0]  total_results2;
    logic        drained2;

    int checks = 0;
    int failures = 0;

    // reference model: buffer contents, phase (0 run, 1 flush, 2 finished)
    logic [11:0] mq[$];
    logic [11:0] exp_q[$];
    int          m_phase = 0;
    bit          m_ovf = 1'b0;
    int          m_total = 0;
    bit          m_ready, m_valid, m_push, m_pop;

    result_capture_fifo dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_result(in_result),
        .in_flags(in_flags), .in_done(in_done), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .overflow(overflow), .total_results(total_results),
        .drained(drained)
    );

    result_capture_fifo #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_result(in_result),
        .in_flags(in_flags), .in_done(in_done), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
        .count(count2), .overflow(overflow2), .total_results(total_results2),
        .drained(drained2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Model: compare pre-edge state, then advance by the inputs applied for this edge
    always @(negedge clk) begin
        if (reset_n) begin
            m_ready = (m_phase == 0) && (mq.size() < 8);
            m_valid = (m_phase != 2) && (mq.size() > 0);
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("count", {28'd0, count}, mq.size());
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("total", {16'd0, total_results}, sat(m_total, 65535));
            chk("total_sat2", {30'd0, total_results2}, sat(m_total, 3));
            chk("drained", {31'd0, drained}, {31'd0, (m_phase == 2)});
            m_push = in_valid && m_ready;
            m_pop  = m_valid && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back({in_flags, in_result});
                exp_q.push_back({in_flags, in_result});
                m_total++;
            end
            if (m_phase == 0 && in_valid && !m_ready) m_ovf = 1'b1;
            if (m_phase == 0) begin
                if (in_done) m_phase = 1;
            end else if (m_phase == 1 && mq.size() == 0) begin
                m_phase = 2;
            end
        end
    end

    // Monitor: every DUT handshake must deliver the oldest expected entry
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", {20'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("out_data", {20'd0, out_data}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] d, input logic [3:0] f,
                        input bit rdy, input bit done);
        in_valid = v; in_result = d; in_flags = f; out_ready = rdy; in_done = done;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; out_ready = 1'b0; in_done = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {20'd0, out_data}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_total", {16'd0, total_results}, 32'd0);
        chk("rst_drained", {31'd0, drained}, 32'd0);
        mq.delete(); exp_q.delete();
        m_phase = 0; m_ovf = 1'b0; m_total = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2;
        apply_reset();

        // single push with consumer ready
        step(1'b1, 8'h05, 4'h1, 1'b1, 1'b0);
        chk("t1_out_data", {20'd0, out_data}, 32'h105);
        chk("t1_total", {16'd0, total_results}, 32'd1);
        repeat (3) step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);

        // fill to full, one dropped push, then drain
        apply_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 8'h10 + 8'(i), 4'h2, 1'b0, 1'b0);
        chk("t2_count", {28'd0, count}, 32'd8);
        chk("t2_overflow", {31'd0, overflow}, 32'd1);
        chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (10) step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);

        // steady push+pop across pointer wrap
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 4'h3, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i * 7), 4'(i), 1'b1, 1'b0);
        chk("t3_count", {28'd0, count}, 32'd3);
        chk("t3_total", {16'd0, total_results}, 32'd23);

        // done with a same-cycle push, then flush
        step(1'b1, 8'h2A, 4'h4, 1'b0, 1'b1);
        chk("t4_count", {28'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 4'($urandom), 1'b1, 1'b0);
        chk("t4_drained", {31'd0, drained}, 32'd1);
        chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) step(1'b1, 8'hEE, 4'hE, 1'b1, 1'b1);

        // reset in the middle of a drain
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'h50 + 8'(i), 4'h5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        chk("t5_count_pre", {28'd0, count}, 32'd5);
        apply_reset();
        step(1'b1, 8'h77, 4'h3, 1'b0, 1'b0);
        chk("t5_count", {28'd0, count}, 32'd1);
        chk("t5_head", {20'd0, out_data}, 32'h377);
        repeat (3) step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);

        // counter saturation on the narrow instance
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 4'h6, 1'b1, 1'b0);
        chk("t6_total2", {30'd0, total_results2}, 32'd3);
        chk("t6_total", {16'd0, total_results}, 32'd5);
        repeat (3) step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);

        // randomized runs ending in done/flush
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int i = 0; i < int'($urandom_range(30, 150)); i++)
                step(($urandom_range(0, 99) < 60), 8'($urandom), 4'($urandom),
                     ($urandom_range(0, 99) < 45), 1'b0);
            step($urandom_range(0, 1) == 1, 8'($urandom), 4'($urandom),
                 $urandom_range(0, 1) == 1, 1'b1);
            for (int i = 0; i < 40; i++)
                step($urandom_range(0, 1) == 1, 8'($urandom), 4'($urandom),
                     ($urandom_range(0, 99) < 70), $urandom_range(0, 1) == 1);
        end

        repeat (12) step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
